// File: rtl/tcm_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the TCM port arbiter.
package tcm_arb_pkg;
  localparam int TCM_ADDR_W = 14;
  localparam int TCM_DATA_W = 64;
  localparam int TCM_BE_W   = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } tcm_state_e;
endpackage

// File: rtl/tcm_port_arbiter_if.sv
// One requester-side bundle of the TCM arbiter: request fields towards the arbiter,
// grant and one-cycle-late response back.
interface tcm_port_arbiter_if;
  import tcm_arb_pkg::*;

  logic                  req;
  logic [TCM_ADDR_W-1:0] addr;
  logic [TCM_DATA_W-1:0] data;
  logic [TCM_BE_W-1:0]   wr;
  logic                  ack;
  logic                  resp_valid;
  logic [TCM_DATA_W-1:0] rdata;

  modport master (output req, addr, data, wr, input ack, resp_valid, rdata);
  modport slave  (input req, addr, data, wr, output ack, resp_valid, rdata);
endinterface

// File: rtl/tcm_rr_arb2.sv
// Two-way round-robin grant: combinational grant in the request cycle, no backpressure.
// The pointer moves only when something is granted; reset leaves it favouring requester 0.
module tcm_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // High when requester 1 won most recently, so requester 0 wins the next tie.
  logic last_b;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              last_b <= 1'b1;
    else if (gnt != 2'b00) last_b <= gnt[1];
  end
endmodule

// File: rtl/tcm_port_arbiter.sv
// Single-port TCM arbiter for core (A) and loader (B) with a RAM clear sequencer.
// Grant is combinational; the response strobe and read data follow one cycle after the grant.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int DEPTH        = 16384,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_i,
  output logic                  busy_o,
  input  logic                  a_req_i,
  input  logic [TCM_ADDR_W-1:0] a_addr_i,
  input  logic [TCM_DATA_W-1:0] a_data_i,
  input  logic [TCM_BE_W-1:0]   a_wr_i,
  output logic                  a_ack_o,
  output logic                  a_resp_valid_o,
  output logic [TCM_DATA_W-1:0] a_data_o,
  input  logic                  b_req_i,
  input  logic [TCM_ADDR_W-1:0] b_addr_i,
  input  logic [TCM_DATA_W-1:0] b_data_i,
  input  logic [TCM_BE_W-1:0]   b_wr_i,
  output logic                  b_ack_o,
  output logic                  b_resp_valid_o,
  output logic [TCM_DATA_W-1:0] b_data_o,
  output logic [TCM_ADDR_W-1:0] mem_addr_o,
  output logic [TCM_DATA_W-1:0] mem_data_o,
  output logic [TCM_BE_W-1:0]   mem_wr_o,
  input  logic [TCM_DATA_W-1:0] mem_data_i
);
  localparam logic [TCM_ADDR_W-1:0] LAST_ADDR = TCM_ADDR_W'(DEPTH - 1);

  tcm_state_e            state, state_nxt;
  logic [TCM_ADDR_W-1:0] cnt, cnt_nxt;
  logic                  boot;
  logic [1:0]            req, gnt;

  // boot marks the first cycle after reset release: nothing is granted while the
  // FSM decides whether to start the automatic clear.
  assign req     = (state == ARB && !boot) ? {b_req_i, a_req_i} : 2'b00;
  assign a_ack_o = gnt[0];
  assign b_ack_o = gnt[1];
  assign busy_o  = (state == CLEAR);

  tcm_rr_arb2 u_rr (
    .clk (clk_i),
    .rst (rst_i),
    .req (req),
    .gnt (gnt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_wr_o   = '0;
    case (state)
      CLEAR: begin
        mem_addr_o = cnt;
        mem_wr_o   = '1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + TCM_ADDR_W'(1);
        end
      end
      default: begin
        if (gnt[0]) begin
          mem_addr_o = a_addr_i;
          mem_data_o = a_data_i;
          mem_wr_o   = a_wr_i;
        end else if (gnt[1]) begin
          mem_addr_o = b_addr_i;
          mem_data_o = b_data_i;
          mem_wr_o   = b_wr_i;
        end
        if (boot ? CLEAR_ON_RST : init_i) state_nxt = CLEAR;
      end
    endcase
  end

  // Read data is captured in the grant cycle, so a write returns the pre-write word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      boot           <= 1'b1;
      cnt            <= '0;
      a_resp_valid_o <= 1'b0;
      b_resp_valid_o <= 1'b0;
      a_data_o       <= '0;
      b_data_o       <= '0;
    end else begin
      boot           <= 1'b0;
      cnt            <= cnt_nxt;
      a_resp_valid_o <= gnt[0];
      b_resp_valid_o <= gnt[1];
      if (gnt[0]) a_data_o <= mem_data_i;
      if (gnt[1]) b_data_o <= mem_data_i;
    end
  end
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Scoreboard bench for tcm_port_arbiter: a cycle-level reference model predicts grants,
// RAM port activity and responses; a separate monitor checks each response strobe.
module tb_tcm_port_arbiter;
  import tcm_arb_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW = TCM_ADDR_W;
  localparam int DW = TCM_DATA_W;
  localparam int BW = TCM_BE_W;

  typedef struct {
    int            stamp;
    logic [DW-1:0] dat;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init = 1'b0;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_wr;

  tcm_port_arbiter_if ia ();
  tcm_port_arbiter_if ib ();

  always #5 clk = ~clk;

  tcm_port_arbiter #(.DEPTH(DEPTH), .CLEAR_ON_RST(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .init_i         (init),
    .busy_o         (busy),
    .a_req_i        (ia.req),
    .a_addr_i       (ia.addr),
    .a_data_i       (ia.data),
    .a_wr_i         (ia.wr),
    .a_ack_o        (ia.ack),
    .a_resp_valid_o (ia.resp_valid),
    .a_data_o       (ia.rdata),
    .b_req_i        (ib.req),
    .b_addr_i       (ib.addr),
    .b_data_i       (ib.data),
    .b_wr_i         (ib.wr),
    .b_ack_o        (ib.ack),
    .b_resp_valid_o (ib.resp_valid),
    .b_data_o       (ib.rdata),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_wr_o       (mem_wr),
    .mem_data_i     (mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // RAM behind the single port: combinational read, byte-enabled write at the edge.
  logic [DW-1:0] ram [DEPTH];
  assign mem_rdata = ram[mem_addr[3:0]];
  always @(posedge clk) if (mem_wr != '0) ram[mem_addr[3:0]] <= merge(ram[mem_addr[3:0]], mem_wdata, mem_wr);

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model state
  logic [DW-1:0] mdl_mem [DEPTH];
  resp_t         q [2][$];
  int            clear_left = 0;
  bit            boot = 1'b1;
  bit            last_was_b = 1'b1;
  int            wait_a = 0, wait_b = 0;
  bit            ga, gb;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;
  logic [BW-1:0] ew;
  resp_t         me;

  always @(negedge clk) begin : model
    if (!rst_n) begin
      boot = 1'b1; clear_left = 0; last_was_b = 1'b1; wait_a = 0; wait_b = 0;
      chk("rst_busy", busy, 0);
      chk("rst_acks", {ib.ack, ia.ack}, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_wdata, 0);
    end else begin
      ga = 1'b0; gb = 1'b0;
      if (!boot && clear_left == 0) begin
        if (ia.req && ib.req) begin ga = last_was_b; gb = !last_was_b; end
        else begin ga = ia.req; gb = ib.req; end
      end
      ea = '0; ed = '0; ew = '0;
      if (clear_left > 0) begin ea = AW'(DEPTH - clear_left); ew = '1; end
      else if (ga) begin ea = ia.addr; ed = ia.data; ew = ia.wr; end
      else if (gb) begin ea = ib.addr; ed = ib.data; ew = ib.wr; end
      chk("busy", busy, (clear_left > 0));
      chk("a_ack", ia.ack, ga);
      chk("b_ack", ib.ack, gb);
      chk("mem_addr", mem_addr, ea);
      chk("mem_data", mem_wdata, ed);
      chk("mem_wr", mem_wr, ew);
      wait_a = (ia.req && !ga && !boot && clear_left == 0) ? wait_a + 1 : 0;
      wait_b = (ib.req && !gb && !boot && clear_left == 0) ? wait_b + 1 : 0;
      chk("max_wait", (wait_a <= 1) && (wait_b <= 1), 1);
      me.stamp = cycle;
      me.dat   = mdl_mem[ea[3:0]];
      if (ga) begin q[0].push_back(me); last_was_b = 1'b0; end
      if (gb) begin q[1].push_back(me); last_was_b = 1'b1; end
      if (ew != '0) mdl_mem[ea[3:0]] = merge(mdl_mem[ea[3:0]], ed, ew);
      if (boot) begin boot = 1'b0; clear_left = DEPTH; end
      else if (clear_left > 0) clear_left--;
      else if (init) clear_left = DEPTH;
    end
  end

  logic [DW-1:0] last_d [2];
  logic [1:0]    rv;
  logic [DW-1:0] rd [2];
  resp_t         pe;

  always @(negedge clk) begin : monitor
    rv = {ib.resp_valid, ia.resp_valid};
    rd[0] = ia.rdata;
    rd[1] = ib.rdata;
    if (!rst_n) begin
      q[0].delete(); q[1].delete();
      last_d[0] = '0; last_d[1] = '0;
      chk("rst_resp_valid", rv, 0);
      chk("rst_a_data", rd[0], 0);
      chk("rst_b_data", rd[1], 0);
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (rv[s] && q[s].size() > 0 && q[s][0].stamp == cycle - 1) begin
          pe = q[s].pop_front();
          last_d[s] = pe.dat;
          chk(s ? "b_resp_data" : "a_resp_data", rd[s], last_d[s]);
        end else begin
          chk(s ? "b_resp_strb" : "a_resp_strb", rv[s], 0);
          chk(s ? "b_data_hold" : "a_data_hold", rd[s], last_d[s]);
          if (q[s].size() > 0 && q[s][0].stamp < cycle) begin
            chk(s ? "b_resp_miss" : "a_resp_miss", rv[s], 1);
            pe = q[s].pop_front();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  task automatic set_a(input bit r, input int adr, input logic [DW-1:0] d, input logic [BW-1:0] w);
    ia.req = r; ia.addr = AW'(adr); ia.data = d; ia.wr = w;
  endtask

  task automatic set_b(input bit r, input int adr, input logic [DW-1:0] d, input logic [BW-1:0] w);
    ib.req = r; ib.addr = AW'(adr); ib.data = d; ib.wr = w;
  endtask

  task automatic new_txn(input int s);
    bit            r;
    int            adr;
    logic [DW-1:0] d;
    logic [BW-1:0] w;
    r   = ($urandom_range(0, 3) != 0);
    adr = $urandom_range(0, DEPTH - 1);
    d   = {$urandom, $urandom};
    w   = ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0;
    if (s == 0) set_a(r, adr, d, w);
    else        set_b(r, adr, d, w);
  endtask

  // Counts busy cycles after a reset release and checks the clear walks 0..DEPTH-1.
  task automatic clear_count(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      @(negedge clk);
      if (busy) begin
        chk({nm, "_addr"}, mem_addr, n);
        chk({nm, "_wr"}, mem_wr, 8'hFF);
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    chk({nm, "_len"}, n, DEPTH);
    chk({nm, "_done"}, busy, 0);
  endtask

  logic [1:0] prev;
  bit         acked_a, acked_b;

  initial begin
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    chk("init_busy", busy, 0);
    chk("init_acks", {ib.ack, ia.ack}, 0);
    chk("init_resp", {ib.resp_valid, ia.resp_valid}, 0);
    chk("init_data", ia.rdata | ib.rdata, 0);
    chk("init_mem_wr", mem_wr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_count("clear1");

    // Both sides requesting continuously: strict alternation starting with A.
    tick();
    set_a(1, 1, '0, '0);
    set_b(1, 2, '0, '0);
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("rr_ack", {ib.ack, ia.ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("rr_lag", {ib.resp_valid, ia.resp_valid}, prev);
      prev = {ib.ack, ia.ack};
      tick();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    sample();
    chk("rr_lag_last", {ib.resp_valid, ia.resp_valid}, prev);

    // Partial byte write then read back.
    tick();
    set_a(1, 5, 64'h1122334455667788, 8'h0F);
    sample();
    chk("wr5_ack", ia.ack, 1);
    tick();
    set_a(1, 5, '0, '0);
    sample();
    chk("rd5_ack", ia.ack, 1);
    tick();
    set_a(0, 0, '0, '0);
    sample();
    chk("rd5_valid", ia.resp_valid, 1);
    chk("rd5_data", ia.rdata, 64'h0000000055667788);

    // Full write by A, read by B the following cycle.
    tick();
    set_a(1, 9, 64'hA5A5012345678_9AB, 8'hFF);
    sample();
    chk("xwr_ack", ia.ack, 1);
    tick();
    set_a(0, 0, '0, '0);
    set_b(1, 9, '0, '0);
    sample();
    chk("xrd_ack", ib.ack, 1);
    tick();
    set_b(0, 0, '0, '0);
    sample();
    chk("xrd_valid", ib.resp_valid, 1);
    chk("xrd_data", ib.rdata, 64'hA5A5012345678_9AB);

    // init pulse while B requests: B still granted, then a full clear, then B again.
    tick();
    set_b(1, 3, '0, '0);
    init = 1'b1;
    sample();
    chk("init_b_ack", ib.ack, 1);
    chk("init_busy0", busy, 0);
    tick();
    init = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      chk("init_clr_busy", busy, 1);
      chk("init_clr_ack", ib.ack, 0);
      tick();
    end
    sample();
    chk("init_post_busy", busy, 0);
    chk("init_post_ack", ib.ack, 1);
    tick();
    set_b(0, 0, '0, '0);

    // Randomized traffic with occasional clears.
    acked_a = 1'b1;
    acked_b = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!ia.req || acked_a) new_txn(0);
      if (!ib.req || acked_b) new_txn(1);
      init = ($urandom_range(0, 59) == 0);
      sample();
      acked_a = ia.ack;
      acked_b = ib.ack;
      tick();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    init = 1'b0;
    for (int i = 0; i < DEPTH + 4 && busy; i++) tick();
    chk("idle_before_abort", busy, 0);

    // Reset in the middle of a clear aborts it; release restarts a full clear.
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (7) tick();
    #1;
    chk("abort_addr", mem_addr, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_resp", {ib.resp_valid, ia.resp_valid}, 0);
    chk("abort_data", ia.rdata | ib.rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_count("clear2");
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
